// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: shared op encodings, FSM states and default width for the mult/div unit
package mult_div_unit_pkg;
    localparam int WIDTH_DEF = 32;
    typedef enum logic [1:0] {OP_MULU = 2'b00, OP_MUL = 2'b01, OP_DIVU = 2'b10, OP_DIV = 2'b11} op_e;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;
endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/result bundle between control FSM (master) and the mult/div unit (slave)
interface mult_div_unit_if
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output start, op, opA, opB, input busy, done, div_by_zero, hi, lo);
    modport slave  (input start, op, opA, opB, output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative shift-add multiplier / restoring divider, one bit per cycle,
// operating on magnitudes with sign correction in a single FIX cycle.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic            clk,
    input  logic            reset,
    mult_div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, sh_q, sh_d, hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic             negq_q, negq_d, negr_q, negr_d, dz_q, dz_d, dbz_q, dbz_d;
    logic             accept, a_neg, b_neg, zero;
    logic [WIDTH:0]   sum, rem_sh, diff;
    logic [2*WIDTH-1:0] prod;
    always_comb begin
        accept = bus.start && (state_q == S_IDLE || state_q == S_DONE);
        a_neg  = bus.op[0] && bus.opA[WIDTH-1];
        b_neg  = bus.op[0] && bus.opB[WIDTH-1];
        zero   = bus.op[1] && bus.opB == '0;
        sum    = acc_q + (sh_q[0] ? {1'b0, a_q} : '0);
        rem_sh = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, a_q};
        prod   = {acc_q[WIDTH-1:0], sh_q};
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                // divide: a set borrow bit means the trial subtraction failed, so restore
                acc_d = op_q[1] ? (diff[WIDTH] ? rem_sh : diff) : {1'b0, sum[WIDTH:1]};
                sh_d  = op_q[1] ? {sh_q[WIDTH-2:0], !diff[WIDTH]} : {sum[0], sh_q[WIDTH-1:1]};
                state_d = (cnt_q == CW'(WIDTH - 1)) ? S_FIX : S_CALC;
            end
            S_FIX: begin
                state_d = S_DONE;
                dbz_d   = dz_q;
                if (dz_q) begin
                    hi_d = sh_q;
                    lo_d = '1;
                end else if (op_q[1]) begin
                    hi_d = negr_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    lo_d = negq_q ? -sh_q : sh_q;
                end else begin
                    {hi_d, lo_d} = negq_q ? -prod : prod;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = state_q;
        endcase
        // divide by zero skips CALC; sh carries the raw dividend to hi
        if (accept) begin
            state_d = zero ? S_FIX : S_CALC;
            op_d    = op_e'(bus.op);
            cnt_d   = '0;
            a_d     = b_neg ? -bus.opB : bus.opB;
            acc_d   = '0;
            sh_d    = (a_neg && !zero) ? -bus.opA : bus.opA;
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
            dz_d    = zero;
            dbz_d   = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_MULU;
            cnt_q   <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            sh_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            dbz_q   <= dbz_d;
        end
    end
    assign bus.busy        = state_q == S_CALC || state_q == S_FIX;
    assign bus.done        = state_q == S_DONE;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors for the mult/div unit with hand-computed results and latencies
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;
    localparam int W = 32;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    mult_div_unit_if #(.WIDTH(W)) bus ();
    mult_div_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
    // called at a negedge; start is seen by the next posedge, returns at the following negedge
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opA   = a;
        bus.opB   = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.opA   = 32'hDEAD_BEEF;
        bus.opB   = 32'h1234_5678;
    endtask
    // n = posedges since the accept edge when done is first seen (100 = timed out)
    task automatic wait_done(input int n0, output int n, output int busy_n);
        n = n0;
        busy_n = 0;
        while (!bus.done && n < 100) begin
            if (bus.busy) busy_n++;
            @(negedge clk);
            n++;
        end
    endtask
    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.op = OP_MULU;
        bus.opA = '0;
        bus.opB = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo} !== '0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b dbz=%b hi=%h lo=%h want all zero", bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask
    task automatic test_mulu();
        int n, b;
        issue(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(0, n, b);
        checks++;
        if (n !== 33) begin errors++; $display("FAIL mulu_latency got %0d want 33", n); end
        checks++;
        if (b !== 33) begin errors++; $display("FAIL mulu_busy_cycles got %0d want 33", b); end
        checks++;
        if ({bus.hi, bus.lo} !== 64'hFFFF_FFFE_0000_0001) begin
            errors++;
            $display("FAIL mulu_result got %h_%h want fffffffe_00000001", bus.hi, bus.lo);
        end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL mulu_busy_at_done got %b want 0", bus.busy); end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL mulu_done_pulse got %b want 0", bus.done); end
    endtask
    task automatic test_mul();
        int n, b;
        issue(OP_MUL, 32'hFFFF_FFFD, 32'd7);
        wait_done(0, n, b);
        checks++;
        if ({bus.hi, bus.lo, bus.div_by_zero} !== {64'hFFFF_FFFF_FFFF_FFEB, 1'b0}) begin
            errors++;
            $display("FAIL mul_signed got %h_%h dbz=%b want ffffffff_ffffffeb dbz=0", bus.hi, bus.lo, bus.div_by_zero);
        end
        @(negedge clk);
    endtask
    task automatic test_div();
        int n, b;
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(0, n, b);
        checks++;
        if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            errors++;
            $display("FAIL div_signed got hi=%h lo=%h want hi=ffffffff lo=fffffffd", bus.hi, bus.lo);
        end
        @(negedge clk);
    endtask
    task automatic test_divu();
        int n, b;
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        checks++;
        if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL hold_during_busy got lo=%h want fffffffd", bus.lo); end
        wait_done(5, n, b);
        checks++;
        if (n !== 33) begin errors++; $display("FAIL divu_latency got %0d want 33", n); end
        checks++;
        if ({bus.hi, bus.lo} !== {32'd2, 32'd14}) begin
            errors++;
            $display("FAIL divu_result got hi=%h lo=%h want hi=2 lo=e", bus.hi, bus.lo);
        end
        @(negedge clk);
    endtask
    task automatic test_div_zero();
        int n, b;
        issue(OP_DIVU, 32'd100, 32'd0);
        wait_done(0, n, b);
        // accept edge enters FIX, the next edge enters DONE
        checks++;
        if (n !== 1) begin errors++; $display("FAIL dz_latency got %0d want 1 edge after accept", n); end
        checks++;
        if ({bus.div_by_zero, bus.hi, bus.lo} !== {1'b1, 32'h64, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL dz_result got dbz=%b hi=%h lo=%h want dbz=1 hi=64 lo=ffffffff", bus.div_by_zero, bus.hi, bus.lo);
        end
        @(negedge clk);
        checks++;
        if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_hold got %b want 1", bus.div_by_zero); end
    endtask
    task automatic test_div_overflow();
        int n, b;
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        checks++;
        if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_clear_on_accept got %b want 0", bus.div_by_zero); end
        wait_done(0, n, b);
        checks++;
        if ({bus.div_by_zero, bus.hi, bus.lo} !== {1'b0, 32'h0, 32'h8000_0000}) begin
            errors++;
            $display("FAIL div_overflow got dbz=%b hi=%h lo=%h want dbz=0 hi=0 lo=80000000", bus.div_by_zero, bus.hi, bus.lo);
        end
        @(negedge clk);
    endtask
    task automatic test_back_to_back();
        int n, b;
        issue(OP_MULU, 32'd5, 32'd6);
        repeat (9) @(negedge clk);
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(10, n, b);
        checks++;
        if (n !== 33) begin errors++; $display("FAIL ignored_start_latency got %0d want 33", n); end
        checks++;
        if ({bus.hi, bus.lo} !== {32'd0, 32'd30}) begin
            errors++;
            $display("FAIL ignored_start_result got hi=%h lo=%h want hi=0 lo=1e", bus.hi, bus.lo);
        end
        issue(OP_MULU, 32'd2, 32'd3);
        checks++;
        if ({bus.busy, bus.done} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_accept got busy=%b done=%b want busy=1 done=0", bus.busy, bus.done);
        end
        wait_done(0, n, b);
        checks++;
        if (n !== 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", n); end
        checks++;
        if (bus.lo !== 32'd6) begin errors++; $display("FAIL b2b_result got lo=%h want 6", bus.lo); end
        @(negedge clk);
    endtask
    task automatic test_reset_abort();
        int n, b, seen;
        issue(OP_DIV, 32'hFFFF_FF9C, 32'd7);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo} !== '0) begin
            errors++;
            $display("FAIL abort_state got busy=%b done=%b dbz=%b hi=%h lo=%h want all zero", bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo);
        end
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d done cycles want 0", seen); end
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(0, n, b);
        checks++;
        if (n !== 33 || {bus.hi, bus.lo} !== {32'd2, 32'd14}) begin
            errors++;
            $display("FAIL after_abort got n=%0d hi=%h lo=%h want n=33 hi=2 lo=e", n, bus.hi, bus.lo);
        end
    endtask
    initial begin
        test_reset();
        test_mulu();
        test_mul();
        test_div();
        test_divu();
        test_div_zero();
        test_div_overflow();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
